// File: rtl/manch_tx_pkg.sv
// Shared definitions for the Manchester transmit scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package manch_tx_pkg;

    // Default frame-timing limits, all counted in nibble slots.
    localparam int DEF_JABBER_NIB = 3072;
    localparam int DEF_IFG_NIB    = 24;
    localparam int DEF_START_TO   = 16;

    // Width of the shared slot counter; wide enough for any sane limit above.
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_XMIT   = 3'd2,
        ST_JABBER = 3'd3,
        ST_IFG    = 3'd4
    } tx_state_t;

endpackage

// File: rtl/manch_rr_arb2.sv
// Two-requester round-robin arbiter with a last-granted pointer.
// Latency: grant is combinational from req0/req1; pointer updates on take.
// Backpressure: none; the caller decides when a grant is taken.
// Ports: clk16x/reset clock and async reset; req0/req1 requests;
//        take commits the current grant to the pointer; gnt0/gnt1 one-hot or zero.
module manch_rr_arb2 (
    input  logic clk16x,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic gnt0,
    output logic gnt1
);

    // 1 = requester 1 won last; reset value makes requester 0 win the first tie.
    logic last1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            gnt0 = last1;
            gnt1 = !last1;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    always_ff @(posedge clk16x or posedge reset) begin
        if (reset) begin
            last1 <= 1'b1;
        end else if (take && (gnt0 || gnt1)) begin
            last1 <= gnt1;
        end
    end

endmodule

// File: rtl/manch_tx_sched.sv
// Schedules two nibble sources onto one Manchester encoder with jabber, start timeout and IFG.
// Latency: grant and encoder outputs register one clk16x cycle after the deciding nib_en.
// Backpressure: rx_busy defers new grants; requests are ignored during IFG.
// Ports: clk16x/reset; nib_en slot strobe; rx_busy carrier sense; req/vld/dat per requester;
//        gnt0/gnt1 grant; enc_txd/enc_tx_en encoder feed; status (jabber, timeout, idle);
//        cntr_clr with frames_sent (wrapping) and jabber_cnt (saturating).
module manch_tx_sched
    import manch_tx_pkg::*;
#(
    parameter int JABBER_NIB = DEF_JABBER_NIB,
    parameter int IFG_NIB    = DEF_IFG_NIB,
    parameter int START_TO   = DEF_START_TO
) (
    input  logic        clk16x,
    input  logic        reset,
    input  logic        nib_en,
    input  logic        rx_busy,
    input  logic        req0,
    input  logic        req1,
    input  logic        vld0,
    input  logic        vld1,
    input  logic [3:0]  dat0,
    input  logic [3:0]  dat1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [3:0]  enc_txd,
    output logic        enc_tx_en,
    output logic        jabber_tx_disable,
    output logic        start_timeout,
    output logic        tx_state_idle,
    input  logic        cntr_clr,
    output logic [15:0] frames_sent,
    output logic [7:0]  jabber_cnt
);

    // Terminal values of the shared slot counter (compared before incrementing).
    localparam logic [CNT_W-1:0] JAB_LAST = CNT_W'(JABBER_NIB - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_NIB - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TO - 1);

    tx_state_t        state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [3:0]       txd_q, txd_d;
    logic             tx_en_q, tx_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_d;
    logic             frame_done, jab_evt, arb_take;
    logic             arb_gnt0, arb_gnt1;
    logic             to_q;
    logic [15:0]      frames_q;
    logic [7:0]       jab_q;

    // Only the granted requester's signals are ever looked at.
    logic       sel_req, sel_vld;
    logic [3:0] sel_dat;
    assign sel_req = gnt_q[1] ? req1 : req0;
    assign sel_vld = gnt_q[1] ? vld1 : vld0;
    assign sel_dat = gnt_q[1] ? dat1 : dat0;

    manch_rr_arb2 u_arb (
        .clk16x (clk16x),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .take   (arb_take),
        .gnt0   (arb_gnt0),
        .gnt1   (arb_gnt1)
    );

    // cnt_q is reused: start-timeout slots in GRANT, nibbles in XMIT, idle slots in IFG.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        txd_d      = txd_q;
        tx_en_d    = tx_en_q;
        cnt_d      = cnt_q;
        to_d       = 1'b0;
        frame_done = 1'b0;
        jab_evt    = 1'b0;
        arb_take   = 1'b0;
        if (nib_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_busy && (req0 || req1)) begin
                        gnt_d    = {arb_gnt1, arb_gnt0};
                        arb_take = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!sel_req) begin
                        gnt_d   = 2'b00;
                        state_d = ST_IDLE;
                    end else if (sel_vld) begin
                        txd_d   = sel_dat;
                        tx_en_d = 1'b1;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_XMIT;
                    end else if (cnt_q == TO_LAST) begin
                        gnt_d   = 2'b00;
                        to_d    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_XMIT: begin
                    if (!sel_vld) begin
                        tx_en_d    = 1'b0;
                        gnt_d      = 2'b00;
                        frame_done = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_IFG;
                    end else if (cnt_q == JAB_LAST) begin
                        // Slot JABBER_NIB itself is cut; the grant stays until req drops.
                        tx_en_d = 1'b0;
                        jab_evt = 1'b1;
                        state_d = ST_JABBER;
                    end else begin
                        txd_d = sel_dat;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_JABBER: begin
                    if (!sel_req) begin
                        gnt_d   = 2'b00;
                        cnt_d   = '0;
                        state_d = ST_IFG;
                    end
                end
                ST_IFG: begin
                    if (cnt_q == IFG_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    gnt_d   = 2'b00;
                    tx_en_d = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk16x or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            txd_q   <= 4'h0;
            tx_en_q <= 1'b0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            txd_q   <= txd_d;
            tx_en_q <= tx_en_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    // Statistics: a clear in the same cycle as an event wins.
    always_ff @(posedge clk16x or posedge reset) begin
        if (reset) begin
            frames_q <= 16'h0000;
            jab_q    <= 8'h00;
        end else if (cntr_clr) begin
            frames_q <= 16'h0000;
            jab_q    <= 8'h00;
        end else begin
            if (frame_done) begin
                frames_q <= frames_q + 16'h0001;
            end
            if (jab_evt && (jab_q != 8'hFF)) begin
                jab_q <= jab_q + 8'h01;
            end
        end
    end

    assign gnt0              = gnt_q[0];
    assign gnt1              = gnt_q[1];
    assign enc_txd           = txd_q;
    assign enc_tx_en         = tx_en_q;
    assign jabber_tx_disable = (state_q == ST_JABBER);
    assign start_timeout     = to_q;
    assign tx_state_idle     = (state_q == ST_IDLE);
    assign frames_sent       = frames_q;
    assign jabber_cnt        = jab_q;

endmodule
